shift_add_mult_ctrl: RTL and testbench

- FSM controller that sequences a shift-and-add multiplier datapath built from three init/load registers: accumulator, multiplicand and multiplier.
- Drives each register's init0/init1/load strobes and an internal iteration counter.
- Samples the multiplier LSB status bit and reports progress through a start/busy/done handshake.
- Sits between the top-level sequencer and the register datapath; contains no data-path arithmetic itself.

---
 rtl/shift_add_mult_ctrl.sv | 121 ++++++++++++
 tb/tb_shift_add_mult_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mult_ctrl.sv
// Sequencing FSM for a shift-and-add multiplier datapath.
// It drives the register init/load strobes and the iteration counter, and reports progress through start/busy/done.
module shift_add_mult_ctrl #(
  parameter int BIT_WIDTH = 16,
  parameter int CNT_W     = $clog2(BIT_WIDTH)  // derived from BIT_WIDTH; leave at default
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             mplier_lsb,
  output logic             acc_init0,
  output logic             acc_load,
  output logic             mcand_init1,
  output logic             mcand_load,
  output logic             mplier_init1,
  output logic             mplier_load,
  output logic [CNT_W-1:0] iter,
  output logic             busy,
  output logic             done
);

  // Handshake: start is a level that is sampled only in IDLE; it is not queued.
  // busy is high for the whole run (INIT..SHIFT), and done is a one-cycle pulse after the last SHIFT.
  // abort cancels a run without a done pulse.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_TEST  = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(BIT_WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] iter_q, iter_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    if (abort) begin
      state_d = S_IDLE;
      iter_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_INIT;
            iter_d  = '0;
          end
        end
        S_INIT: begin
          state_d = S_TEST;
          iter_d  = '0;
        end
        S_TEST:  state_d = mplier_lsb ? S_ADD : S_SHIFT;
        S_ADD:   state_d = S_SHIFT;
        S_SHIFT: begin
          // The counter holds on the last iteration so it never wraps.
          if (iter_q == ITER_LAST) begin
            state_d = S_DONE;
          end else begin
            iter_d  = iter_q + CNT_W'(1);
            state_d = S_TEST;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: begin
          state_d = S_IDLE;
          iter_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    acc_init0    = 1'b0;
    acc_load     = 1'b0;
    mcand_init1  = 1'b0;
    mcand_load   = 1'b0;
    mplier_init1 = 1'b0;
    mplier_load  = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state_q)
      S_INIT: begin
        acc_init0    = 1'b1;
        mcand_init1  = 1'b1;
        mplier_init1 = 1'b1;
        busy         = 1'b1;
      end
      S_TEST: busy = 1'b1;
      S_ADD: begin
        acc_load = 1'b1;
        busy     = 1'b1;
      end
      S_SHIFT: begin
        mcand_load  = 1'b1;
        mplier_load = 1'b1;
        busy        = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign iter = iter_q;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Bench for shift_add_mult_ctrl: a small datapath model closes the mplier_lsb loop.
// Each observed cycle is compared against an expected strobe trace that is built from B's bits.
module tb_shift_add_mult_ctrl;

  localparam int BW = 16;
  localparam int CW = 4;
  localparam int VW = 8 + CW;

  localparam logic [7:0] V_INIT  = 8'hAA;
  localparam logic [7:0] V_TEST  = 8'h02;
  localparam logic [7:0] V_ADD   = 8'h42;
  localparam logic [7:0] V_SHIFT = 8'h16;
  localparam logic [7:0] V_DONE  = 8'h01;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          mplier_lsb = 1'b0;
  logic          acc_init0, acc_load, mcand_init1, mcand_load;
  logic          mplier_init1, mplier_load, busy, done;
  logic [CW-1:0] iter;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0]   acc_m, mcand_m;
  logic [15:0]   mpl_m, op_a, op_b;
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] msk_q[$];
  logic [VW-1:0] obs_log[$];
  bit            timed_out;

  shift_add_mult_ctrl #(.BIT_WIDTH(BW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mplier_lsb(mplier_lsb),
    .acc_init0(acc_init0), .acc_load(acc_load), .mcand_init1(mcand_init1),
    .mcand_load(mcand_load), .mplier_init1(mplier_init1), .mplier_load(mplier_load),
    .iter(iter), .busy(busy), .done(done)
  );

  // clock block
  always #5 clk = ~clk;

  function automatic logic [VW-1:0] cur_obs();
    return {acc_init0, acc_load, mcand_init1, mcand_load, mplier_init1, mplier_load,
            busy, done, iter};
  endfunction

  // Expected trace for one multiplication with multiplier b (appended to exp_q/msk_q).
  function automatic void build_trace(input logic [15:0] b);
    exp_q.push_back({V_INIT, CW'(0)});
    msk_q.push_back({8'hFF, CW'(0)});
    for (int i = 0; i < BW; i++) begin
      exp_q.push_back({V_TEST, CW'(i)});
      msk_q.push_back('1);
      if (b[i]) begin
        exp_q.push_back({V_ADD, CW'(i)});
        msk_q.push_back('1);
      end
      exp_q.push_back({V_SHIFT, CW'(i)});
      msk_q.push_back('1);
    end
    exp_q.push_back({V_DONE, CW'(BW - 1)});
    msk_q.push_back('1);
  endfunction

  // Datapath model: apply the strobes seen this cycle and present the new multiplier LSB.
  task automatic apply_model();
    if (acc_init0)    acc_m = '0;
    if (acc_load)     acc_m = acc_m + mcand_m;
    if (mcand_init1)  mcand_m = {16'h0, op_a};
    if (mcand_load)   mcand_m = mcand_m << 1;
    if (mplier_init1) mpl_m = op_b;
    if (mplier_load)  mpl_m = mpl_m >> 1;
    mplier_lsb = mpl_m[0];
  endtask

  // driver: one start pulse, then record each cycle until done or the cycle budget expires
  task automatic exec_run(input logic [15:0] a, input logic [15:0] b);
    op_a = a;
    op_b = b;
    obs_log.delete();
    timed_out = 1'b1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 0; c < 80; c++) begin
      obs_log.push_back(cur_obs());
      apply_model();
      if (done === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests_run++;
      if (cur_obs() !== '0) begin
        tests_failed++;
        $display("FAIL reset_hold cyc%0d: got %h want 0", c, cur_obs());
      end
    end
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests_run++;
      if (cur_obs() !== '0) begin
        tests_failed++;
        $display("FAIL idle_after_reset cyc%0d: got %h want 0", c, cur_obs());
      end
    end
  endtask

  task automatic test_run(input logic [15:0] a, input logic [15:0] b);
    int n;
    exp_q.delete();
    msk_q.delete();
    build_trace(b);
    exec_run(a, b);
    tests_run++;
    if (timed_out) begin
      tests_failed++;
      $display("FAIL run_timeout b=%h: no done within budget", b);
    end
    tests_run++;
    if (obs_log.size() != 34 + $countones(b)) begin
      tests_failed++;
      $display("FAIL run_latency b=%h: got %0d want %0d", b, obs_log.size(), 34 + $countones(b));
    end
    n = (obs_log.size() < exp_q.size()) ? obs_log.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      tests_run++;
      if ((obs_log[k] & msk_q[k]) !== (exp_q[k] & msk_q[k])) begin
        tests_failed++;
        $display("FAIL run_trace b=%h cyc%0d: got %h want %h", b, k, obs_log[k], exp_q[k]);
      end
    end
    tests_run++;
    if (acc_m !== 32'(a) * 32'(b)) begin
      tests_failed++;
      $display("FAIL run_product a=%h b=%h: got %h want %h", a, b, acc_m, 32'(a) * 32'(b));
    end
  endtask

  task automatic test_busy_abort();
    logic [VW-1:0] o;
    exp_q.delete();
    msk_q.delete();
    op_a = 16'($urandom_range(0, 16'hFFFF));
    op_b = 16'($urandom_range(0, 16'hFFFF));
    build_trace(op_b);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      o = cur_obs();
      tests_run++;
      if ((o & msk_q[k]) !== (exp_q[k] & msk_q[k])) begin
        tests_failed++;
        $display("FAIL busy_start_ignored cyc%0d: got %h want %h", k, o, exp_q[k]);
      end
      apply_model();
      start = (k > 0) && (exp_q[k][CW-1:0] == CW'(7));
      if (k > 0 && exp_q[k][CW-1:0] == CW'(9)) begin
        start = 1'b0;
        abort = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk) abort = 1'b0;
    tests_run++;
    if (cur_obs() !== '0) begin
      tests_failed++;
      $display("FAIL abort_to_idle: got %h want 0", cur_obs());
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests_run++;
      if (cur_obs() !== '0) begin
        tests_failed++;
        $display("FAIL abort_no_done cyc%0d: got %h want 0", c, cur_obs());
      end
    end
  endtask

  task automatic test_async_reset_and_held_start();
    bit            seen_add;
    int            l;
    logic [VW-1:0] o;
    op_a = 16'h1234;
    op_b = 16'hFFFF;
    seen_add = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      apply_model();
      if (acc_load === 1'b1) begin
        seen_add = 1'b1;
        break;
      end
      @(negedge clk);
    end
    tests_run++;
    if (!seen_add) begin
      tests_failed++;
      $display("FAIL reach_add: acc_load never rose");
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (cur_obs() !== '0) begin
      tests_failed++;
      $display("FAIL async_reset_clear: got %h want 0", cur_obs());
    end
    @(negedge clk);
    tests_run++;
    if (cur_obs() !== '0) begin
      tests_failed++;
      $display("FAIL reset_held_idle: got %h want 0", cur_obs());
    end
    rst_n = 1'b1;
    // Two back-to-back runs with start held, separated by exactly one IDLE cycle.
    op_a = 16'($urandom_range(0, 16'hFFFF));
    op_b = 16'($urandom_range(0, 16'hFFFF));
    exp_q.delete();
    msk_q.delete();
    build_trace(op_b);
    l = exp_q.size();
    exp_q.push_back('0);
    msk_q.push_back({8'hFF, CW'(0)});
    build_trace(op_b);
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < exp_q.size(); k++) begin
      o = cur_obs();
      tests_run++;
      if ((o & msk_q[k]) !== (exp_q[k] & msk_q[k])) begin
        tests_failed++;
        $display("FAIL held_start cyc%0d: got %h want %h", k, o, exp_q[k]);
      end
      apply_model();
      if (k == l + 1) start = 1'b0;
      if (k < exp_q.size() - 1) @(negedge clk);
    end
    tests_run++;
    if (acc_m !== 32'(op_a) * 32'(op_b)) begin
      tests_failed++;
      $display("FAIL held_product: got %h want %h", acc_m, 32'(op_a) * 32'(op_b));
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_run(16'($urandom_range(1, 16'hFFFF)), 16'h0000);
    test_run(16'($urandom_range(1, 16'hFFFF)), 16'hFFFF);
    test_run(16'($urandom_range(1, 16'hFFFF)), 16'h0005);
    for (int r = 0; r < 6; r++)
      test_run(16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF)));
    test_busy_abort();
    test_async_reset_and_held_start();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
